// File: rtl/fpga_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM states and the
// "all off" major mode used for the reset configuration.
package fpga_cmd_decoder_pkg;

  localparam logic [3:0] OP_NOP         = 4'b0000;
  localparam logic [3:0] OP_SET_CONFREG = 4'b0001;
  localparam logic [3:0] OP_SET_REG     = 4'b0010;

  localparam logic [2:0] MODE_OFF = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

endpackage

// File: rtl/fpga_cmd_decoder_spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin, plus one edge flop that
// yields single-cycle rise/fall pulses in the ck_1356meg domain.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Not reset: the chain just tracks the pin, and the decoder FSM is held in
  // IDLE by rst long enough for the chain to settle.
  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    r_prev <= r_sync[SYNC_STAGES-1];
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/fpga_cmd_decoder.sv
// SPI command decoder in the ck_1356meg domain: stages a conf word (applied on
// safe_strobe) and writes a small register file. Optional FPGA_CMD_READBACK_EN.
module fpga_cmd_decoder
  import fpga_cmd_decoder_pkg::*;
#(
  parameter int CMD_W       = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int MODE_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] CONF_RESET = {MODE_OFF, {(DATA_W-MODE_W){1'b0}}}
) (
  input  logic                         ck_1356meg,
  input  logic                         rst,
  input  logic                         spck,
  input  logic                         mosi,
  input  logic                         ncs,
  output logic                         miso,
  input  logic                         safe_strobe,
  output logic [DATA_W-1:0]            conf_word,
  output logic [MODE_W-1:0]            major_mode,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         conf_pending,
  output logic                         conf_update,
  output logic                         cmd_err
);

  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int AF_W   = CMD_W - 4 - DATA_W;
  localparam int CNT_W  = $clog2(CMD_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CMD_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_W);

  logic w_spck_lvl, w_spck_rise, w_spck_fall;
  logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
  logic w_mosi;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_spck_sync (
    .i_clk  (ck_1356meg),
    .i_d    (spck),
    .o_level(w_spck_lvl),
    .o_rise (w_spck_rise),
    .o_fall (w_spck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
    .i_clk  (ck_1356meg),
    .i_d    (ncs),
    .o_level(w_ncs_lvl),
    .o_rise (w_ncs_rise),
    .o_fall (w_ncs_fall)
  );

  // mosi only needs its level, taken at the same depth as the spck level.
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  always_ff @(posedge ck_1356meg) begin
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  state_t              r_state;
  logic [CMD_W-1:0]    r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [DATA_W-1:0]   r_staged;
  logic [DATA_W-1:0]   r_conf;
  logic                r_pending;
  logic                r_update;
  logic                r_err;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic [3:0]          w_opcode;
  logic [AF_W-1:0]     w_afield;
  logic [DATA_W-1:0]   w_data;
  logic                w_addr_ok;

  // The whole field between opcode and data is range-checked so that stray
  // high address bits are rejected rather than aliased onto a register.
  assign w_opcode  = r_shift[CMD_W-1 -: 4];
  assign w_afield  = r_shift[DATA_W +: AF_W];
  assign w_data    = r_shift[DATA_W-1:0];
  assign w_addr_ok = (32'(w_afield) < NUM_REGS);

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_staged  <= CONF_RESET;
      r_conf    <= CONF_RESET;
      r_pending <= 1'b0;
      r_update  <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_update <= 1'b0;
      r_err    <= 1'b0;

      // Apply sees the old staged value; a same-cycle SET_CONFREG below
      // overrides r_staged/r_pending so the new value remains pending.
      if (safe_strobe && r_pending) begin
        r_conf    <= r_staged;
        r_update  <= 1'b1;
        r_pending <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_ncs_fall) begin
            r_state   <= ST_SHIFT;
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_spck_rise) begin
            r_shift <= {r_shift[CMD_W-2:0], w_mosi};
            if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (w_ncs_rise) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_state <= ST_IDLE;
          if (r_bit_cnt != CNT_FULL) begin
            r_err <= 1'b1;
          end else begin
            case (w_opcode)
              OP_NOP: ;
              OP_SET_CONFREG: begin
                r_staged  <= w_data;
                r_pending <= 1'b1;
              end
              OP_SET_REG: begin
                if (w_addr_ok) r_regs[w_afield[ADDR_W-1:0]] <= w_data;
                else           r_err <= 1'b1;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign conf_word    = r_conf;
  assign major_mode   = r_conf[DATA_W-1 -: MODE_W];
  assign conf_pending = r_pending;
  assign conf_update  = r_update;
  assign cmd_err      = r_err;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

`ifdef FPGA_CMD_READBACK_EN
  logic [CMD_W-1:0] r_rb;
  logic             r_sticky;

  // Snapshot at frame start, then shift out on spck falls so the ARM can
  // sample on the following rise.
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_rb     <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_ncs_fall) begin
        r_rb     <= {r_pending, r_sticky, {(CMD_W-2-DATA_W){1'b0}}, r_conf};
        r_sticky <= 1'b0;
      end else if (w_spck_fall) begin
        r_rb <= {r_rb[CMD_W-2:0], 1'b0};
      end
      if (r_err) r_sticky <= 1'b1;
    end
  end

  assign miso     = ~w_ncs_lvl & r_rb[CMD_W-1];
  assign w_unused = &{1'b0, w_spck_lvl};
`else
  assign miso     = 1'b0;
  assign w_unused = &{1'b0, w_spck_lvl, w_spck_fall, w_ncs_lvl};
`endif

endmodule

// File: tb/tb_fpga_cmd_decoder.sv
// Bench for fpga_cmd_decoder: directed vector table, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_fpga_cmd_decoder;

  localparam int SYNC = 2;
  localparam int H    = 4;

  logic        ck_1356meg = 1'b0;
  logic        rst = 1'b1;
  logic        spck = 1'b0;
  logic        mosi = 1'b0;
  logic        ncs = 1'b1;
  logic        safe_strobe = 1'b0;
  logic        miso;
  logic [7:0]  conf_word;
  logic [2:0]  major_mode;
  logic [31:0] regs_flat;
  logic        conf_pending;
  logic        conf_update;
  logic        cmd_err;

  always #5 ck_1356meg = ~ck_1356meg;

  fpga_cmd_decoder #(
    .CMD_W(16), .DATA_W(8), .NUM_REGS(4), .MODE_W(3),
    .SYNC_STAGES(SYNC), .CONF_RESET(8'hE0)
  ) dut (
    .ck_1356meg  (ck_1356meg),
    .rst         (rst),
    .spck        (spck),
    .mosi        (mosi),
    .ncs         (ncs),
    .miso        (miso),
    .safe_strobe (safe_strobe),
    .conf_word   (conf_word),
    .major_mode  (major_mode),
    .regs_flat   (regs_flat),
    .conf_pending(conf_pending),
    .conf_update (conf_update),
    .cmd_err     (cmd_err)
  );

  int total = 0;
  int bad   = 0;
  int n_err = 0;
  int n_upd = 0;

  always @(negedge ck_1356meg) begin
    if (cmd_err)     n_err++;
    if (conf_update) n_upd++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ck_1356meg);
    #1;
  endtask

  task automatic send_bits(input int first, input int last, input int len,
                           input logic [16:0] val, inout logic [15:0] rb);
    for (int i = first; i < last; i++) begin
      mosi = val[len-1-i];
      tick(H);
      if (i < 16) rb[15-i] = miso;
      spck = 1'b1;
      tick(H);
      spck = 1'b0;
    end
  endtask

  task automatic send_frame(input int len, input logic [16:0] val, input bit dec_strobe,
                            output logic [15:0] rb);
    logic [15:0] r;
    r   = '0;
    ncs = 1'b0;
    tick(H);
    send_bits(0, len, len, val, r);
    tick(H);
    ncs  = 1'b1;
    mosi = 1'b0;
    if (dec_strobe) begin
      tick(SYNC + 1);
      safe_strobe = 1'b1;
      tick(1);
      safe_strobe = 1'b0;
      tick(3);
    end else begin
      tick(SYNC + 4);
    end
    rb = r;
  endtask

  task automatic strobe();
    safe_strobe = 1'b1;
    tick(1);
    safe_strobe = 1'b0;
    tick(2);
  endtask

  typedef struct {
    int          len;
    logic [16:0] val;
    bit          strb;
    logic [7:0]  e_conf;
    bit          e_pend;
    int          e_err;
    int          e_upd;
    int          ridx;
    logic [7:0]  rval;
  } vec_t;

  vec_t tbl[16];

  logic [7:0] m_conf, m_staged;
  bit         m_pend;
  logic [7:0] m_regs[4];

  initial begin
    logic [15:0] rbd;
    int e0, u0;
    logic [15:0] rb_exp;

    // len = -1 means a bare safe_strobe, no frame
    tbl[0]  = '{16, 17'h01021, 1'b0, 8'hE0, 1'b1, 0, 0, 0, 8'h00};
    tbl[1]  = '{-1, 17'h00000, 1'b1, 8'h21, 1'b0, 0, 1, 0, 8'h00};
    tbl[2]  = '{16, 17'h01041, 1'b0, 8'h21, 1'b1, 0, 0, 0, 8'h00};
    tbl[3]  = '{16, 17'h01082, 1'b0, 8'h21, 1'b1, 0, 0, 0, 8'h00};
    tbl[4]  = '{-1, 17'h00000, 1'b1, 8'h82, 1'b0, 0, 1, 0, 8'h00};
    tbl[5]  = '{-1, 17'h00000, 1'b1, 8'h82, 1'b0, 0, 0, 0, 8'h00};
    tbl[6]  = '{16, 17'h02355, 1'b0, 8'h82, 1'b0, 0, 0, 3, 8'h55};
    tbl[7]  = '{16, 17'h02755, 1'b0, 8'h82, 1'b0, 1, 0, 3, 8'h55};
    tbl[8]  = '{15, 17'h0084C, 1'b0, 8'h82, 1'b0, 1, 0, 3, 8'h55};
    tbl[9]  = '{17, 17'h02133, 1'b0, 8'h82, 1'b0, 1, 0, 1, 8'h00};
    tbl[10] = '{16, 17'h0F000, 1'b0, 8'h82, 1'b0, 1, 0, 0, 8'h00};
    tbl[11] = '{0,  17'h00000, 1'b0, 8'h82, 1'b0, 1, 0, 0, 8'h00};
    tbl[12] = '{16, 17'h00000, 1'b0, 8'h82, 1'b0, 0, 0, 0, 8'h00};
    tbl[13] = '{16, 17'h021A5, 1'b0, 8'h82, 1'b0, 0, 0, 1, 8'hA5};
    tbl[14] = '{16, 17'h02411, 1'b0, 8'h82, 1'b0, 1, 0, 1, 8'hA5};
    tbl[15] = '{16, 17'h03000, 1'b0, 8'h82, 1'b0, 1, 0, 3, 8'h55};

    tick(5);
    rst = 1'b0;
    tick(2);
    chk("rst_conf",    32'(conf_word),    32'hE0);
    chk("rst_major",   32'(major_mode),   32'h7);
    chk("rst_regs",    regs_flat,         32'h0);
    chk("rst_miso",    32'(miso),         32'h0);
    chk("rst_pending", 32'(conf_pending), 32'h0);
    chk("rst_update",  32'(conf_update),  32'h0);
    chk("rst_err",     32'(cmd_err),      32'h0);

    for (int k = 0; k < 16; k++) begin
      e0 = n_err;
      u0 = n_upd;
      if (tbl[k].len >= 0) send_frame(tbl[k].len, tbl[k].val, 1'b0, rbd);
      if (tbl[k].strb) strobe();
      chk($sformatf("v%0d_conf", k),  32'(conf_word),    32'(tbl[k].e_conf));
      chk($sformatf("v%0d_major", k), 32'(major_mode),   32'(tbl[k].e_conf[7:5]));
      chk($sformatf("v%0d_pend", k),  32'(conf_pending), 32'(tbl[k].e_pend));
      chk($sformatf("v%0d_err", k),   32'(n_err - e0),   32'(tbl[k].e_err));
      chk($sformatf("v%0d_upd", k),   32'(n_upd - u0),   32'(tbl[k].e_upd));
      chk($sformatf("v%0d_reg", k),   32'(regs_flat[tbl[k].ridx*8 +: 8]), 32'(tbl[k].rval));
      chk($sformatf("v%0d_miso", k),  32'(miso),         32'h0);
    end

    // strobe landing in the DECODE cycle of a SET_CONFREG
    send_frame(16, 17'h01011, 1'b0, rbd);
    strobe();
    chk("pre_dec_conf", 32'(conf_word), 32'h11);
    send_frame(16, 17'h01041, 1'b0, rbd);
    send_frame(16, 17'h01082, 1'b0, rbd);
    u0 = n_upd;
    send_frame(16, 17'h010C3, 1'b1, rbd);
    chk("dec_conf", 32'(conf_word),    32'h82);
    chk("dec_pend", 32'(conf_pending), 32'h1);
    chk("dec_upd",  32'(n_upd - u0),   32'h1);
    strobe();
    chk("dec_conf2", 32'(conf_word),    32'hC3);
    chk("dec_pend2", 32'(conf_pending), 32'h0);

    // readback (miso stays 0 in the default build)
    send_frame(16, 17'h01021, 1'b0, rbd);
    strobe();
`ifdef FPGA_CMD_READBACK_EN
    rb_exp = 16'h0021;
`else
    rb_exp = 16'h0000;
`endif
    send_frame(16, 17'h00000, 1'b0, rbd);
    chk("rb_clean", 32'(rbd), 32'(rb_exp));
    send_frame(16, 17'h0F000, 1'b0, rbd);
`ifdef FPGA_CMD_READBACK_EN
    rb_exp = 16'h4021;
`endif
    send_frame(16, 17'h00000, 1'b0, rbd);
    chk("rb_sticky", 32'(rbd), 32'(rb_exp));

    // reset in the middle of a frame, ncs still low afterwards
    e0 = n_err;
    rbd = '0;
    ncs = 1'b0;
    tick(H);
    send_bits(0, 8, 16, 17'h010AA, rbd);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    send_bits(8, 16, 16, 17'h010AA, rbd);
    tick(H);
    ncs = 1'b1;
    tick(SYNC + 4);
    chk("mid_rst_conf", 32'(conf_word),    32'hE0);
    chk("mid_rst_pend", 32'(conf_pending), 32'h0);
    chk("mid_rst_err",  32'(n_err - e0),   32'h0);
    chk("mid_rst_regs", regs_flat,         32'h0);
    send_frame(16, 17'h010AA, 1'b0, rbd);
    chk("post_rst_pend", 32'(conf_pending), 32'h1);
    strobe();
    chk("post_rst_conf", 32'(conf_word), 32'hAA);

    // randomized frames against the reference model
    m_conf = 8'hAA;
    m_staged = 8'hAA;
    m_pend = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    for (int it = 0; it < 40; it++) begin
      int len, sel, op, af, ee, eu;
      logic [7:0]  dat;
      logic [15:0] word;
      logic [16:0] v;
      sel = $urandom_range(0, 9);
      len = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      sel = $urandom_range(0, 5);
      op  = (sel == 0) ? 0 : (sel <= 2) ? 1 : (sel <= 4) ? 2 : $urandom_range(3, 15);
      af  = $urandom_range(0, 5);
      dat = 8'($urandom);
      word = 16'((op << 12) | (af << 8) | dat);
      v = (len == 15) ? 17'(word >> 1) : (len == 17) ? {word, 1'b1} : {1'b0, word};
      ee = 0;
      eu = 0;
      if (len != 16) ee = 1;
      else if (op == 1) begin m_staged = dat; m_pend = 1'b1; end
      else if (op == 2) begin
        if (af < 4) m_regs[af] = dat;
        else ee = 1;
      end else if (op != 0) ee = 1;
      e0 = n_err;
      u0 = n_upd;
      send_frame(len, v, 1'b0, rbd);
      if ($urandom_range(0, 1) == 1) begin
        strobe();
        if (m_pend) begin m_conf = m_staged; m_pend = 1'b0; eu = 1; end
      end
      chk($sformatf("r%0d_conf", it), 32'(conf_word),    32'(m_conf));
      chk($sformatf("r%0d_pend", it), 32'(conf_pending), 32'(m_pend));
      chk($sformatf("r%0d_err", it),  32'(n_err - e0),   32'(ee));
      chk($sformatf("r%0d_upd", it),  32'(n_upd - u0),   32'(eu));
      chk($sformatf("r%0d_regs", it), regs_flat, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
